// File: rtl/free_list.sv
`default_nettype none
// ============================================================================
// free_list : physical-register free list with one-cycle rollback to the
//             committed allocation pointer on flush.
// Optional  : FREE_LIST_OVF_CHK_EN adds a sticky err_o for illegal free/commit.
// Revision  : 1.0
// ============================================================================
`ifndef DECODE_WIDTH
`define DECODE_WIDTH 4
`endif
`ifndef COMMIT_WIDTH
`define COMMIT_WIDTH 4
`endif

module free_list #(
  parameter int PHY_REG_NUM  = 64,
  parameter int DECODE_WIDTH = `DECODE_WIDTH,
  parameter int COMMIT_WIDTH = `COMMIT_WIDTH,
  localparam int PW = $clog2(PHY_REG_NUM)
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [DECODE_WIDTH-1:0]          alloc_req_i,
  output logic                             alloc_ready_o,
  output logic [DECODE_WIDTH-1:0][PW-1:0]  preg_o,
  input  logic [COMMIT_WIDTH-1:0]          commit_i,
  input  logic [COMMIT_WIDTH-1:0]          free_i,
  input  logic [COMMIT_WIDTH-1:0][PW-1:0]  old_preg_i,
  input  logic                             restore_i,
  output logic [PW:0]                      free_cnt_o
`ifdef FREE_LIST_OVF_CHK_EN
  ,
  output logic                             err_o
`endif
);

  localparam logic [PW:0] c_full = (PW+1)'(PHY_REG_NUM);
  localparam logic [PW:0] c_one  = (PW+1)'(1);

  logic [PW-1:0] r_list [PHY_REG_NUM];
  logic [PW-1:0] r_head, r_tail, r_arch_head;
  logic [PW:0]   r_cnt, r_arch_cnt;

  logic [PW:0]   w_nreq, w_nfree, w_ncommit;
  logic [PW-1:0] w_free_slot [COMMIT_WIDTH];
  logic          w_fire;
  logic [PW-1:0] w_head_n, w_arch_head_n;
  logic [PW:0]   w_cnt_n, w_arch_cnt_n;

  // Requesting slots take consecutive entries from head, in ascending slot order.
  always_comb begin
    w_nreq = '0;
    preg_o = '0;
    for (int i = 0; i < DECODE_WIDTH; i++) begin
      if (alloc_req_i[i]) begin
        preg_o[i] = r_list[r_head + w_nreq[PW-1:0]];
        w_nreq    = w_nreq + c_one;
      end
    end
  end

  always_comb begin
    w_nfree   = '0;
    w_ncommit = '0;
    for (int j = 0; j < COMMIT_WIDTH; j++) begin
      w_free_slot[j] = r_tail + w_nfree[PW-1:0];
      if (free_i[j])   w_nfree   = w_nfree + c_one;
      if (commit_i[j]) w_ncommit = w_ncommit + c_one;
    end
  end

  assign alloc_ready_o = (r_cnt >= w_nreq) & ~restore_i;
  assign w_fire        = (w_nreq != '0) & alloc_ready_o;
  assign free_cnt_o    = r_cnt;

  assign w_arch_head_n = r_arch_head + w_ncommit[PW-1:0];
  assign w_arch_cnt_n  = r_arch_cnt - w_ncommit + w_nfree;

  // A flush lands on the committed state after this cycle's commit/free.
  always_comb begin
    w_head_n = r_head;
    w_cnt_n  = r_cnt + w_nfree;
    if (restore_i) begin
      w_head_n = w_arch_head_n;
      w_cnt_n  = w_arch_cnt_n;
    end else if (w_fire) begin
      w_head_n = r_head + w_nreq[PW-1:0];
      w_cnt_n  = r_cnt - w_nreq + w_nfree;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < PHY_REG_NUM; i++) begin
        r_list[i] <= PW'(i);
      end
      r_head      <= '0;
      r_tail      <= '0;
      r_arch_head <= '0;
      r_cnt       <= c_full;
      r_arch_cnt  <= c_full;
    end else begin
      for (int j = 0; j < COMMIT_WIDTH; j++) begin
        if (free_i[j]) begin
          r_list[w_free_slot[j]] <= old_preg_i[j];
        end
      end
      r_head      <= w_head_n;
      r_tail      <= r_tail + w_nfree[PW-1:0];
      r_arch_head <= w_arch_head_n;
      r_cnt       <= w_cnt_n;
      r_arch_cnt  <= w_arch_cnt_n;
    end
  end

`ifdef FREE_LIST_OVF_CHK_EN
  logic r_err;
  logic w_err_set;

  assign w_err_set = (({1'b0, r_cnt} + {1'b0, w_nfree}) > {1'b0, c_full})
                   | (({1'b0, r_arch_cnt} + {1'b0, w_nfree}) < {1'b0, w_ncommit})
                   | (|(free_i & ~commit_i));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_err <= 1'b0;
    end else if (w_err_set) begin
      r_err <= 1'b1;
    end
  end

  assign err_o = r_err;
`endif

endmodule
`default_nettype wire
